// File: rtl/clk_meter_pkg.sv
// clk_meter_pkg
//   Shared definitions for the clock meter: the measurement FSM state
//   encoding. The encoding values are fixed because debug tooling decodes
//   them from the register bank.
package clk_meter_pkg;

  typedef enum logic [1:0] {
    ARMED = 2'd0,  // waiting for the first edge after reset or signal loss
    RUN   = 2'd1,  // measuring; every rise closes one period
    LOST  = 2'd2   // no rising edge within the timeout window
  } state_e;

endpackage

// File: rtl/clk_meter_sync_2ff.sv
// sync_2ff
//   Generic 1-bit two-flop synchronizer for bringing an asynchronous level
//   into the clk domain. Also used for the other asynchronous inputs of the
//   capture path.
// Ports:
//   clk   - destination clock
//   rst_n - asynchronous active-low reset, clears both stages
//   i_d   - asynchronous input level
//   o_q   - synchronized level, two clk edges of latency
module sync_2ff (
  input  logic clk,
  input  logic rst_n,
  input  logic i_d,
  output logic o_q
);

  logic r_meta;
  logic r_sync;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_meta <= 1'b0;
      r_sync <= 1'b0;
    end else begin
      r_meta <= i_d;
      r_sync <= r_meta;
    end
  end

  assign o_q = r_sync;

endmodule

// File: rtl/clk_meter.sv
// clk_meter
//   Measures period and high time of a slow asynchronous clock-like signal
//   in clk cycles, flags lock when the period stays near EXP_PERIOD and
//   flags loss when rising edges stop arriving.
// Ports:
//   clk        - measurement clock
//   rst_n      - asynchronous active-low reset
//   sig_in     - signal under measurement (asynchronous)
//   period_out - last measured period, cycles
//   high_out   - high time within that period, cycles
//   meas_valid - one-cycle pulse when period_out/high_out update
//   locked     - LOCK_CNT consecutive in-tolerance periods seen
//   sig_lost   - no rising edge for TIMEOUT cycles
module clk_meter
  import clk_meter_pkg::*;
#(
  parameter int CNT_W      = 16,
  parameter int EXP_PERIOD = 20,
  parameter int TOL        = 1,
  parameter int LOCK_CNT   = 4,
  parameter int TIMEOUT    = 64
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             sig_in,
  output logic [CNT_W-1:0] period_out,
  output logic [CNT_W-1:0] high_out,
  output logic             meas_valid,
  output logic             locked,
  output logic             sig_lost
);

  localparam int                GOOD_W   = $clog2(LOCK_CNT + 1);
  localparam logic [CNT_W-1:0]  LAST_CNT = CNT_W'(TIMEOUT - 1);
  localparam logic [CNT_W:0]    EXP_W    = (CNT_W + 1)'(EXP_PERIOD);
  localparam logic [CNT_W:0]    TOL_W    = (CNT_W + 1)'(TOL);
  localparam logic [GOOD_W-1:0] GOOD_MAX = GOOD_W'(LOCK_CNT);

  logic              w_sig_s;
  logic              r_sig_d;
  logic              w_rise;
  logic [CNT_W-1:0]  r_per_cnt;
  logic [CNT_W-1:0]  r_hi_cnt;
  state_e            r_state;
  state_e            w_state_next;
  logic              w_timeout;
  logic              w_meas;
  logic              w_to_lost;
  logic              w_clr_lock;
  logic [CNT_W:0]    w_per_p1;
  logic [CNT_W:0]    w_dev;
  logic              w_good;
  logic [GOOD_W-1:0] w_good_cnt_next;
  logic [GOOD_W-1:0] r_good_cnt;
  logic [CNT_W-1:0]  r_period;
  logic [CNT_W-1:0]  r_high;
  logic              r_meas_valid;
  logic              r_locked;
  logic              r_sig_lost;

  // Input conditioning and edge detect
  sync_2ff u_sync (
    .clk   (clk),
    .rst_n (rst_n),
    .i_d   (sig_in),
    .o_q   (w_sig_s)
  );

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_sig_d <= 1'b0;
    end else begin
      r_sig_d <= w_sig_s;
    end
  end

  assign w_rise = w_sig_s & ~r_sig_d;

  // Period / high-time counters. The rise cycle itself is high, so hi_cnt
  // restarts at 1. per_cnt may wrap while LOST; only rise matters there.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_per_cnt <= '0;
      r_hi_cnt  <= '0;
    end else if (w_rise) begin
      r_per_cnt <= '0;
      r_hi_cnt  <= CNT_W'(1);
    end else begin
      r_per_cnt <= r_per_cnt + CNT_W'(1);
      if (w_sig_s) begin
        r_hi_cnt <= r_hi_cnt + CNT_W'(1);
      end
    end
  end

  assign w_timeout = (r_per_cnt == LAST_CNT);

  // FSM: state register
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state <= ARMED;
    end else begin
      r_state <= w_state_next;
    end
  end

  // FSM: next state
  always_comb begin
    w_state_next = r_state;
    case (r_state)
      ARMED: begin
        if (w_rise) begin
          w_state_next = RUN;
        end else if (w_timeout) begin
          w_state_next = LOST;
        end
      end
      RUN: begin
        if (!w_rise && w_timeout) begin
          w_state_next = LOST;
        end
      end
      LOST: begin
        if (w_rise) begin
          w_state_next = ARMED;
        end
      end
      default: w_state_next = ARMED;
    endcase
  end

  // FSM: outputs. Lock state is cleared on the edge that enters LOST so that
  // sig_lost and locked never disagree.
  always_comb begin
    w_meas     = (r_state == RUN) && w_rise;
    w_to_lost  = (r_state != LOST) && (w_state_next == LOST);
    w_clr_lock = (r_state == LOST) || w_to_lost;
  end

  // Tolerance check on the closing period, one bit wider than the counter
  // so per_cnt+1 and the subtraction never wrap.
  always_comb begin
    w_per_p1 = {1'b0, r_per_cnt} + (CNT_W + 1)'(1);
    if (w_per_p1 >= EXP_W) begin
      w_dev = w_per_p1 - EXP_W;
    end else begin
      w_dev = EXP_W - w_per_p1;
    end
    w_good = (w_dev <= TOL_W);
    if (!w_good) begin
      w_good_cnt_next = '0;
    end else if (r_good_cnt == GOOD_MAX) begin
      w_good_cnt_next = GOOD_MAX;
    end else begin
      w_good_cnt_next = r_good_cnt + GOOD_W'(1);
    end
  end

  // Measurement, lock and loss registers
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_period     <= '0;
      r_high       <= '0;
      r_meas_valid <= 1'b0;
      r_good_cnt   <= '0;
      r_locked     <= 1'b0;
      r_sig_lost   <= 1'b0;
    end else begin
      r_meas_valid <= w_meas;
      if (w_meas) begin
        r_period <= w_per_p1[CNT_W-1:0];
        r_high   <= r_hi_cnt;
      end
      if (w_clr_lock) begin
        r_good_cnt <= '0;
        r_locked   <= 1'b0;
      end else if (w_meas) begin
        r_good_cnt <= w_good_cnt_next;
        r_locked   <= (w_good_cnt_next == GOOD_MAX);
      end
      if (w_to_lost) begin
        r_sig_lost <= 1'b1;
      end else if ((r_state == LOST) && w_rise) begin
        r_sig_lost <= 1'b0;
      end
    end
  end

  assign period_out = r_period;
  assign high_out   = r_high;
  assign meas_valid = r_meas_valid;
  assign locked     = r_locked;
  assign sig_lost   = r_sig_lost;

endmodule

// File: tb/tb_clk_meter.sv
// tb_clk_meter
//   Directed bench for clk_meter. Every rise that should close a measurement
//   pushes the expected {period, high, locked} into a scoreboard queue; each
//   meas_valid pulse pops and compares. sig_in is driven on the falling edge
//   and outputs are sampled on the falling edge.
module tb_clk_meter;

  localparam int CNT_W    = 16;
  localparam int EXP      = 20;
  localparam int TOL      = 1;
  localparam int LOCK_CNT = 4;
  localparam int TIMEOUT  = 64;
  // falling edges from driving sig_in high to the first edge after the
  // registered rise: 2 synchronizer stages + edge detect
  localparam int RISE_LAT = 3;

  logic             clk    = 1'b0;
  logic             rst_n  = 1'b1;
  logic             sig_in = 1'b0;
  logic [CNT_W-1:0] period_out;
  logic [CNT_W-1:0] high_out;
  logic             meas_valid;
  logic             locked;
  logic             sig_lost;

  clk_meter #(
    .CNT_W      (CNT_W),
    .EXP_PERIOD (EXP),
    .TOL        (TOL),
    .LOCK_CNT   (LOCK_CNT),
    .TIMEOUT    (TIMEOUT)
  ) dut (
    .clk        (clk),
    .rst_n      (rst_n),
    .sig_in     (sig_in),
    .period_out (period_out),
    .high_out   (high_out),
    .meas_valid (meas_valid),
    .locked     (locked),
    .sig_lost   (sig_lost)
  );

  always #5 clk = ~clk;

  typedef struct packed {
    logic [CNT_W-1:0] per;
    logic [CNT_W-1:0] hi;
    logic             lk;
  } exp_t;

  exp_t sb[$];
  int   n_checks   = 0;
  int   n_pass     = 0;
  int   n_fail     = 0;
  int   step_no    = 0;
  int   skip_rises = 1;   // rises still needed before measurements start
  int   good_model = 0;
  int   prev_p     = 0;
  int   prev_h     = 0;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] expv);
    n_checks++;
    assert (obs === expv) n_pass++;
    else begin
      n_fail++;
      $display("FAIL %s: observed %0d expected %0d (t=%0t)", tag, obs, expv, $time);
      $error("comparison %s did not hold", tag);
    end
  endtask

  // Compare any pulse against the scoreboard head.
  task automatic monitor();
    exp_t e;
    if (meas_valid === 1'b1) begin
      check("pulse_expected", 32'(sb.size() > 0), 1);
      if (sb.size() > 0) begin
        e = sb.pop_front();
        check("period_out", 32'(period_out), 32'(e.per));
        check("high_out", 32'(high_out), 32'(e.hi));
        check("locked_at_pulse", 32'(locked), 32'(e.lk));
        $display("meas: period=%0d high=%0d locked=%0b (exp %0d/%0d/%0b)",
                 period_out, high_out, locked, e.per, e.hi, e.lk);
      end
    end
  endtask

  task automatic step(input logic v);
    @(negedge clk);
    monitor();
    sig_in = v;
    step_no++;
  endtask

  // Model of a rise being driven: closes the previous period if measuring.
  task automatic on_rise();
    bit good;
    exp_t e;
    if (skip_rises > 0) begin
      skip_rises--;
    end else begin
      good = (prev_p >= EXP - TOL) && (prev_p <= EXP + TOL);
      if (!good)                      good_model = 0;
      else if (good_model < LOCK_CNT) good_model++;
      e.per = CNT_W'(prev_p);
      e.hi  = CNT_W'(prev_h);
      e.lk  = (good_model == LOCK_CNT);
      sb.push_back(e);
    end
  endtask

  task automatic period(input int p, input int h);
    on_rise();
    for (int i = 0; i < p; i++) step(i < h);
    prev_p = p;
    prev_h = h;
  endtask

  // Drive a rise, keep sig_in high for high_len steps then low, and measure
  // how many falling edges pass before sig_lost is seen.
  task automatic rise_then_hold(input string tag, input int high_len, input int total);
    int t0;
    int seen;
    on_rise();
    t0   = step_no + 1;
    seen = -1;
    for (int i = 0; i < total; i++) begin
      step(i < high_len);
      if (seen < 0 && sig_lost === 1'b1) seen = step_no - t0;
    end
    check(tag, 32'(seen), 32'(RISE_LAT + TIMEOUT));
    check("locked_when_lost", 32'(locked), 0);
    skip_rises = 2;
    good_model = 0;
  endtask

  task automatic do_reset();
    check("sb_empty_before_reset", 32'(sb.size()), 0);
    @(negedge clk);
    sig_in = 1'b0;
    rst_n  = 1'b0;
    repeat (2) @(negedge clk);
    rst_n = 1'b1;
    sb.delete();
    skip_rises = 1;
    good_model = 0;
  endtask

  initial begin
    // Reset values
    #1 rst_n = 1'b0;
    repeat (3) @(negedge clk);
    check("rst_period_out", 32'(period_out), 0);
    check("rst_high_out", 32'(high_out), 0);
    check("rst_meas_valid", 32'(meas_valid), 0);
    check("rst_locked", 32'(locked), 0);
    check("rst_sig_lost", 32'(sig_lost), 0);
    rst_n = 1'b1;

    // 1: square wave 20/10, first rise only arms, lock on 4th pulse
    repeat (6) period(20, 10);

    // 2: one 22-cycle period breaks lock; four good periods relock
    period(22, 10);
    repeat (5) period(20, 10);

    // 3: alternating 19/21 from reset, all within tolerance
    do_reset();
    period(19, 9);
    period(21, 10);
    period(19, 9);
    period(21, 10);

    // 4: stop after a rise (measures the last 21), then resume
    rise_then_hold("lost_latency_low", 10, 100);
    on_rise();
    for (int i = 0; i < 20; i++) begin
      step(i < 10);
      if (i == 2) check("lost_held_before_rise_reg", 32'(sig_lost), 1);
      if (i == 3) check("lost_clears_after_rise", 32'(sig_lost), 0);
    end
    prev_p = 20;
    prev_h = 10;
    period(20, 10);
    period(20, 10);
    period(20, 10);

    // 5: constant high times out like constant low
    rise_then_hold("lost_latency_high", 100, 100);
    check("lost_stays_while_high", 32'(sig_lost), 1);
    repeat (5) step(1'b0);

    // 6: async reset mid-period while locked
    do_reset();
    repeat (6) period(20, 10);
    on_rise();
    for (int i = 0; i < 8; i++) step(1'b1);
    check("locked_before_async_rst", 32'(locked), 1);
    check("sb_empty_mid_period", 32'(sb.size()), 0);
    #2;
    rst_n  = 1'b0;
    sig_in = 1'b0;
    #1;
    check("arst_period_out", 32'(period_out), 0);
    check("arst_high_out", 32'(high_out), 0);
    check("arst_meas_valid", 32'(meas_valid), 0);
    check("arst_locked", 32'(locked), 0);
    check("arst_sig_lost", 32'(sig_lost), 0);
    @(negedge clk);
    rst_n = 1'b1;
    sb.delete();
    skip_rises = 1;
    good_model = 0;
    repeat (6) period(20, 10);
    on_rise();
    for (int i = 0; i < 20; i++) step(i < 10);
    check("sb_drained_at_end", 32'(sb.size()), 0);
    check("locked_at_end", 32'(locked), 1);

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
